// File: rtl/game_dumper_if.sv
// Bus bundle for game_dumper: SDRAM read port plus the outgoing byte stream.
// Stream handshake: a byte moves on any clk edge where out_valid && out_ready;
// once out_valid is high it stays high with out_data unchanged until that edge.
interface game_dumper_if;
  logic [21:0] mem_addr;
  logic        mem_rd;
  logic [7:0]  mem_rdata;
  logic        mem_rdata_valid;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;

  modport master (
    output mem_addr, mem_rd, out_data, out_valid,
    input  mem_rdata, mem_rdata_valid, out_ready
  );

  modport slave (
    input  mem_addr, mem_rd, out_data, out_valid,
    output mem_rdata, mem_rdata_valid, out_ready
  );
endinterface

// File: rtl/game_dumper.sv
// Streams a loaded game back out of SDRAM as an iNES image:
// regenerated 16-byte header, then PRG bytes, then CHR bytes.
// One SDRAM read is outstanding at a time; each byte is read, sent, then the
// next read is issued.
module game_dumper #(
  parameter logic [21:0] CHR_BASE = 22'h200000,
  parameter logic [21:0] PRG_BASE = 22'h000000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start_i,
  input  logic [31:0]          mapper_flags_i,
  input  logic [7:0]           prg_banks_i,
  input  logic [7:0]           chr_banks_i,
  game_dumper_if.master        bus,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o,
  output logic [2:0]           state_o
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_REQ  = 3'd2,
    S_WAIT = 3'd3,
    S_SEND = 3'd4,
    S_DONE = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  idx_q, idx_d;
  logic        chr_sec_q, chr_sec_d;
  logic [21:0] addr_q, addr_d;
  logic [21:0] left_q, left_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [31:0] flags_q, flags_d;
  logic [7:0]  prg_q, prg_d;
  logic [7:0]  chr_q, chr_d;

  logic [7:0]  chr_n;
  logic [7:0]  hdr_byte;
  logic [21:0] prg_count;
  logic [21:0] chr_count;

  // CHR RAM carts have no CHR image to dump.
  assign chr_n     = flags_q[15] ? 8'd0 : chr_q;
  assign prg_count = {prg_q, 14'b0};
  assign chr_count = {1'b0, chr_n, 13'b0};

  // Header byte selected by the current header index.
  always_comb begin
    hdr_byte = 8'h00;
    case (idx_q)
      4'd0: hdr_byte = 8'h4E;
      4'd1: hdr_byte = 8'h45;
      4'd2: hdr_byte = 8'h53;
      4'd3: hdr_byte = 8'h1A;
      4'd4: hdr_byte = prg_q;
      4'd5: hdr_byte = chr_n;
      4'd6: hdr_byte = {flags_q[3:0], 3'b000, flags_q[14]};
      4'd7: hdr_byte = {flags_q[7:4], 4'b0000};
      default: hdr_byte = 8'h00;
    endcase
  end

  // Next-state and datapath updates for the dump sequencer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    chr_sec_d = chr_sec_q;
    addr_d    = addr_q;
    left_d    = left_q;
    data_d    = data_q;
    done_d    = done_q;
    err_d     = err_q;
    flags_d   = flags_q;
    prg_d     = prg_q;
    chr_d     = chr_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          flags_d = mapper_flags_i;
          prg_d   = prg_banks_i;
          chr_d   = chr_banks_i;
          idx_d   = 4'd0;
          if (prg_banks_i == 8'd0) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_HDR;
          end
        end
      end
      S_HDR: begin
        if (bus.out_ready) begin
          idx_d = idx_q + 4'd1;
          if (idx_q == 4'd15) begin
            state_d   = S_REQ;
            chr_sec_d = 1'b0;
            addr_d    = PRG_BASE;
            left_d    = prg_count;
          end
        end
      end
      S_REQ: state_d = S_WAIT;
      S_WAIT: begin
        if (bus.mem_rdata_valid) begin
          data_d  = bus.mem_rdata;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        if (bus.out_ready) begin
          addr_d = addr_q + 22'd1;
          left_d = left_q - 22'd1;
          if (left_q > 22'd1) begin
            state_d = S_REQ;
          end else if (!chr_sec_q && (chr_n != 8'd0)) begin
            chr_sec_d = 1'b1;
            addr_d    = CHR_BASE;
            left_d    = chr_count;
            state_d   = S_REQ;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= 4'd0;
      chr_sec_q <= 1'b0;
      addr_q    <= 22'd0;
      left_q    <= 22'd0;
      data_q    <= 8'd0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      flags_q   <= 32'd0;
      prg_q     <= 8'd0;
      chr_q     <= 8'd0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      chr_sec_q <= chr_sec_d;
      addr_q    <= addr_d;
      left_q    <= left_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      flags_q   <= flags_d;
      prg_q     <= prg_d;
      chr_q     <= chr_d;
    end
  end

  assign bus.mem_addr  = addr_q;
  assign bus.mem_rd    = (state_q == S_REQ);
  assign bus.out_valid = (state_q == S_HDR) || (state_q == S_SEND);
  assign bus.out_data  = (state_q == S_HDR) ? hdr_byte : data_q;
  assign busy_o        = (state_q == S_HDR) || (state_q == S_REQ) ||
                         (state_q == S_WAIT) || (state_q == S_SEND);
  assign done_o        = done_q;
  assign error_o       = err_q;
  assign state_o       = state_q;

endmodule

// File: tb/tb_game_dumper.sv
// Bench for game_dumper: SDRAM model with variable latency, random sink
// backpressure, and a scoreboard comparing the stream against expected bytes.
module tb_game_dumper;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] flags;
  logic [7:0]  prg;
  logic [7:0]  chr;
  logic        busy;
  logic        done;
  logic        error;
  logic [2:0]  state;

  game_dumper_if bus ();

  game_dumper dut (
    .clk            (clk),
    .reset          (reset),
    .start_i        (start),
    .mapper_flags_i (flags),
    .prg_banks_i    (prg),
    .chr_banks_i    (chr),
    .bus            (bus),
    .busy_o         (busy),
    .done_o         (done),
    .error_o        (error),
    .state_o        (state)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- shared state ----------------
  logic [7:0]  exp_q[$];
  int          checks;
  int          passes;
  int          byte_cnt;
  int          rd_cnt;
  logic        rd_pending;
  int          lat_cnt;
  logic [21:0] pend_addr;
  logic        lat_random;
  logic        ready_rand;
  logic        stall_hold;
  logic [7:0]  held_data;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic logic [7:0] mem_byte(input logic [21:0] a);
    logic [7:0] hi;
    hi = a[15:8] * 8'd7;
    return a[7:0] ^ hi ^ (a[21] ? 8'hA5 : 8'h00);
  endfunction

  // Queue the full expected stream for one dump.
  task automatic push_dump(input logic [7:0] p, input logic [7:0] c, input logic [31:0] f);
    logic [7:0] cn;
    cn = f[15] ? 8'd0 : c;
    exp_q.push_back(8'h4E);
    exp_q.push_back(8'h45);
    exp_q.push_back(8'h53);
    exp_q.push_back(8'h1A);
    exp_q.push_back(p);
    exp_q.push_back(cn);
    exp_q.push_back({f[3:0], 3'b000, f[14]});
    exp_q.push_back({f[7:4], 4'b0000});
    for (int i = 0; i < 8; i++) exp_q.push_back(8'h00);
    for (int i = 0; i < int'(p) * 16384; i++) exp_q.push_back(mem_byte(22'h000000 + 22'(i)));
    for (int i = 0; i < int'(cn) * 8192; i++) exp_q.push_back(mem_byte(22'h200000 + 22'(i)));
  endtask

  // ---------------- SDRAM model ----------------
  initial begin
    bus.mem_rdata       = 8'h00;
    bus.mem_rdata_valid = 1'b0;
    rd_pending = 1'b0;
    lat_cnt    = 0;
    pend_addr  = 22'd0;
    rd_cnt     = 0;
    forever begin
      @(negedge clk);
      if (reset && bus.mem_rd) begin
        check("one_outstanding", {31'd0, rd_pending}, 32'd0);
        rd_pending = 1'b1;
        rd_cnt++;
        pend_addr = bus.mem_addr;
        lat_cnt   = lat_random ? int'($urandom_range(1, 7)) : 1;
      end
      @(posedge clk);
      #1;
      bus.mem_rdata_valid = 1'b0;
      if (lat_cnt > 0) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          bus.mem_rdata_valid = 1'b1;
          bus.mem_rdata       = mem_byte(pend_addr);
          rd_pending          = 1'b0;
        end
      end
    end
  end

  // ---------------- sink ready driver ----------------
  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.out_ready = ready_rand ? ($urandom_range(0, 99) < 30) : 1'b1;
    end
  end

  // ---------------- stream monitor / scoreboard ----------------
  initial begin
    stall_hold = 1'b0;
    held_data  = 8'h00;
    byte_cnt   = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        stall_hold = 1'b0;
      end else if (bus.out_valid) begin
        if (stall_hold) check("stall_data", {24'd0, bus.out_data}, {24'd0, held_data});
        if (bus.out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL extra_byte: got %0h expected no byte at %0t", bus.out_data, $time);
          end else begin
            check("stream_byte", {24'd0, bus.out_data}, {24'd0, exp_q.pop_front()});
          end
          byte_cnt++;
          stall_hold = 1'b0;
        end else begin
          stall_hold = 1'b1;
          held_data  = bus.out_data;
        end
      end else if (stall_hold) begin
        checks++;
        $display("FAIL valid_held: got out_valid 0 expected 1 at %0t", $time);
        stall_hold = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},      {31'd0, busy},          32'd0);
    check({tag, "_done"},      {31'd0, done},          32'd0);
    check({tag, "_error"},     {31'd0, error},         32'd0);
    check({tag, "_out_valid"}, {31'd0, bus.out_valid}, 32'd0);
    check({tag, "_mem_rd"},    {31'd0, bus.mem_rd},    32'd0);
    check({tag, "_mem_addr"},  {10'd0, bus.mem_addr},  32'd0);
    check({tag, "_out_data"},  {24'd0, bus.out_data},  32'd0);
    check({tag, "_state"},     {29'd0, state},         32'd0);
  endtask

  task automatic wait_bytes(input int n, input int bound, input string nm);
    int i;
    for (i = 0; i < bound; i++) begin
      if (byte_cnt >= n) break;
      @(posedge clk);
      #1;
    end
    if (byte_cnt < n) begin
      checks++;
      $display("FAIL %s: got %0d bytes expected %0d", nm, byte_cnt, n);
    end
  endtask

  task automatic wait_done(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (done) break;
      @(posedge clk);
      #1;
    end
    check("done_reached", {31'd0, done}, 32'd1);
  endtask

  task automatic abort_dump();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic saw_valid;
    int   rd_before;
    checks = 0;
    passes = 0;
    reset = 1'b0;
    start = 1'b0;
    flags = 32'd0;
    prg   = 8'd0;
    chr   = 8'd0;
    lat_random = 1'b0;
    ready_rand = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    reset = 1'b1;

    // Full dump: 1 PRG bank, 1 CHR bank, mapper 1, vertical mirror bit set.
    prg = 8'd1; chr = 8'd1; flags = 32'h0000_4001;
    push_dump(prg, chr, flags);
    byte_cnt = 0; rd_cnt = 0;
    pulse_start();
    check("t1_busy", {31'd0, busy}, 32'd1);
    wait_done(80000);
    check("t1_bytes", byte_cnt, 32'd24592);
    check("t1_reads", rd_cnt, 32'd24576);
    check("t1_busy_end", {31'd0, busy}, 32'd0);
    check("t1_error", {31'd0, error}, 32'd0);
    check("t1_queue_empty", exp_q.size(), 32'd0);

    // Backpressure and variable latency, with a rejected-looking start mid-dump.
    ready_rand = 1'b1; lat_random = 1'b1;
    push_dump(prg, chr, flags);
    byte_cnt = 0;
    pulse_start();
    check("t2_done_cleared", {31'd0, done}, 32'd0);
    wait_bytes(40, 3000, "t2_progress");
    prg = 8'd0;
    pulse_start();
    check("t2_restart_ignored_err", {31'd0, error}, 32'd0);
    check("t2_restart_ignored_busy", {31'd0, busy}, 32'd1);
    prg = 8'd1;
    wait_bytes(116, 5000, "t2_prg100");
    begin : find_pending
      int i;
      for (i = 0; i < 3000; i++) begin
        @(negedge clk);
        if (rd_pending && lat_cnt >= 3) break;
      end
      if (!(rd_pending && lat_cnt >= 3)) begin
        checks++;
        $display("FAIL t2_pending: got no long pending read expected one");
      end
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_reset_values("t2_midreset");
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    saw_valid = 1'b0;
    repeat (12) begin
      @(negedge clk);
      saw_valid = saw_valid | bus.out_valid;
    end
    check("t2_late_data_dropped", {31'd0, saw_valid}, 32'd0);
    ready_rand = 1'b0; lat_random = 1'b0;

    // Fresh start after reset; CHR RAM flag hides CHR, mapper 0x23.
    prg = 8'd1; chr = 8'd2; flags = 32'h0000_8023;
    push_dump(prg, chr, flags);
    byte_cnt = 0;
    pulse_start();
    wait_bytes(66, 1000, "t3_progress");
    abort_dump();

    // Zero PRG banks is rejected; next good start clears the error.
    prg = 8'd0; chr = 8'd1; flags = 32'h0000_0000;
    rd_before = rd_cnt;
    pulse_start();
    check("t4_error", {31'd0, error}, 32'd1);
    check("t4_busy", {31'd0, busy}, 32'd0);
    saw_valid = 1'b0;
    repeat (6) begin
      @(negedge clk);
      saw_valid = saw_valid | bus.out_valid;
    end
    check("t4_no_valid", {31'd0, saw_valid}, 32'd0);
    check("t4_no_reads", rd_cnt, rd_before);
    prg = 8'd2;
    push_dump(prg, chr, flags);
    byte_cnt = 0;
    pulse_start();
    check("t4_error_cleared", {31'd0, error}, 32'd0);
    check("t4_busy_again", {31'd0, busy}, 32'd1);
    wait_bytes(46, 1000, "t4_progress");
    abort_dump();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
